// File: rtl/instr_fetch_unit.sv
// PC and fetch stage: drives the ROM address, presents {instr, pc, pc+4, valid} to decode.
// Optional FETCH_COUNT_EN enables the fetched-instruction counter on fetch_count.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES   = 128,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        instr_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    state_t      state;
    logic [31:0] pc;
    logic        valid_q;
    logic [31:0] cand;
    logic        misaligned;
    logic        out_of_range;
    logic        advance;

    always_comb begin
        cand         = redirect_valid ? redirect_target : pc + 32'd4;
        misaligned   = |cand[1:0];
        out_of_range = cand > LAST_PC;
        advance      = (state == RUN) && !stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            valid_q     <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            fault_pc    <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        // Misalignment wins over range when both apply
                        if (misaligned || out_of_range) begin
                            state       <= FAULT;
                            valid_q     <= 1'b0;
                            fault       <= 1'b1;
                            fault_cause <= misaligned ? 2'b01 : 2'b10;
                            fault_pc    <= cand;
                        end else begin
                            pc <= cand;
                        end
                    end
                end
                FAULT: begin
                    state   <= FAULT;
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr      = pc;
    assign instr_pc       = pc;
    assign instr_pc_plus4 = pc + 32'd4;
    assign instr_valid    = valid_q;
    assign instr          = valid_q ? imem_rd : NOP_INSTR;

`ifdef FETCH_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'h0;
        end else if (advance && !misaligned && !out_of_range) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, address sweep,
// fetch counter check and randomized traffic against a reference model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_valid;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

`ifdef FETCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    instr_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rd         (imem_rd),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc_plus4  (instr_pc_plus4),
        .instr_valid     (instr_valid),
        .fault           (fault),
        .fault_cause     (fault_cause),
        .fault_pc        (fault_pc),
        .fetch_count     (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_rd = rom_word(imem_addr);

    // Reference model: mode 0 boot, 1 run, 2 fault
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_fault;
    logic [1:0]  m_cause;
    logic [31:0] m_fpc;
    logic [31:0] m_cnt;

    task automatic model_step(input bit r, input bit s, input bit v,
                              input logic [31:0] t);
        logic [31:0] nxt;
        if (r) begin
            m_mode  = 0;
            m_pc    = 32'h0;
            m_fault = 1'b0;
            m_cause = 2'b00;
            m_fpc   = 32'h0;
            m_cnt   = 32'h0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && !s) begin
            nxt = v ? t : m_pc + 32'd4;
            if (nxt % 4 != 0) begin
                m_mode = 2; m_fault = 1'b1; m_cause = 2'd1; m_fpc = nxt;
            end else if (nxt > 32'd124) begin
                m_mode = 2; m_fault = 1'b1; m_cause = 2'd2; m_fpc = nxt;
            end else begin
                m_pc = nxt;
                if (CNT_EN) m_cnt = m_cnt + 32'd1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic v;
        v = (m_mode == 1);
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_pc", instr_pc, m_pc);
        chk("pc_plus4", instr_pc_plus4, m_pc + 32'd4);
        chk("valid", {31'b0, instr_valid}, {31'b0, v});
        chk("instr", instr, v ? rom_word(m_pc) : 32'h0000_0013);
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
        chk("cause", {30'b0, fault_cause}, {30'b0, m_cause});
        chk("fault_pc", fault_pc, m_fpc);
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    task automatic cyc(input bit r, input bit s, input bit v,
                       input logic [31:0] t);
        @(negedge clk);
        reset           = r;
        stall           = s;
        redirect_valid  = v;
        redirect_target = t;
        @(posedge clk);
        model_step(r, s, v, t);
        #1;
        check_model();
    endtask

    typedef struct {
        bit          rst;
        bit          stl;
        bit          rv;
        logic [31:0] tgt;
        logic [31:0] pc;
        bit          valid;
        bit          flt;
        logic [1:0]  cause;
        logic [31:0] fpc;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit v, logic [31:0] t,
                                logic [31:0] p, bit vl, bit f,
                                logic [1:0] c, logic [31:0] fp);
        vec_t x;
        x.rst = r; x.stl = s; x.rv = v; x.tgt = t;
        x.pc = p; x.valid = vl; x.flt = f; x.cause = c; x.fpc = fp;
        return x;
    endfunction

    vec_t vecs[$];

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;

        vecs.push_back(mk(1, 0, 0, 32'h00, 32'h00, 0, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h00, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h04, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h08, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 1, 32'h22, 32'h08, 0, 1, 2'd1, 32'h22));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h08, 0, 1, 2'd1, 32'h22));
        vecs.push_back(mk(1, 0, 0, 32'h00, 32'h00, 0, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h00, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h04, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h08, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h0C, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h10, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 1, 1, 32'h40, 32'h10, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 1, 1, 32'h40, 32'h10, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 1, 1, 32'h40, 32'h10, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 1, 32'h40, 32'h40, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 1, 32'h7C, 32'h7C, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 1, 32'h7C, 32'h7C, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h7C, 0, 1, 2'd2, 32'h80));
        vecs.push_back(mk(0, 1, 1, 32'h00, 32'h7C, 0, 1, 2'd2, 32'h80));
        vecs.push_back(mk(1, 0, 1, 32'h40, 32'h00, 0, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h00, 1, 0, 2'd0, 32'h00));
        vecs.push_back(mk(0, 0, 1, 32'h80, 32'h00, 0, 1, 2'd2, 32'h80));

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].tgt);
            chk($sformatf("vec%0d_pc", i), instr_pc, vecs[i].pc);
            chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid},
                {31'b0, vecs[i].valid});
            chk($sformatf("vec%0d_fault", i), {31'b0, fault},
                {31'b0, vecs[i].flt});
            chk($sformatf("vec%0d_cause", i), {30'b0, fault_cause},
                {30'b0, vecs[i].cause});
            chk($sformatf("vec%0d_fpc", i), fault_pc, vecs[i].fpc);
        end

        // Full sequential sweep to the last word and off the end
        cyc(1, 0, 0, 32'h0);
        cyc(0, 0, 0, 32'h0);
        chk("sweep_start", instr_pc, 32'h0);
        for (int i = 1; i < 32; i++) begin
            cyc(0, 0, 0, 32'h0);
            chk("sweep_pc", instr_pc, 32'(i * 4));
        end
        cyc(0, 0, 0, 32'h0);
        chk("end_fault", {31'b0, fault}, 32'h1);
        chk("end_cause", {30'b0, fault_cause}, 32'h2);
        chk("end_fpc", fault_pc, 32'h80);
        chk("end_instr", instr, 32'h0000_0013);
        chk("end_pc", instr_pc, 32'h7C);

        // 10 unstalled RUN edges plus 2 stalled ones
        cyc(1, 0, 0, 32'h0);
        cyc(0, 0, 0, 32'h0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 32'h0);
        cyc(0, 1, 0, 32'h0);
        cyc(0, 1, 1, 32'h8);
        chk("fetch_count_10", fetch_count, CNT_EN ? 32'd10 : 32'd0);

        // Randomized traffic
        cyc(1, 0, 0, 32'h0);
        for (int i = 0; i < 600; i++) begin
            bit          r;
            bit          s;
            bit          v;
            logic [31:0] t;
            r = ($urandom_range(0, 24) == 0);
            s = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0:       t = $urandom;
                1:       t = 32'h7C + 32'($urandom_range(0, 8));
                2:       t = 32'($urandom_range(0, 127));
                default: t = 32'($urandom_range(0, 31) * 4);
            endcase
            cyc(r, s, v, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
